// File: rtl/avmm_cfg_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM configuration slave among NUM_REQ requesters.
// Forwards the granted command unchanged and aborts slave transactions that stall too long.
module avmm_cfg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 256,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 32,
    parameter int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0]          req_read,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [ADDR_W-1:0]           avmm_address_out,
    output logic [DATA_W-1:0]           avmm_writedata_out,
    output logic [DATA_W/8-1:0]         avmm_byteenable_out,
    output logic                        avmm_write_out,
    output logic                        avmm_read_out,
    input  logic [DATA_W-1:0]           avmm_readdata,
    input  logic                        avmm_waitrequest,
    output logic                        busy,
    output logic [GNT_W-1:0]            grant_id,
    output logic                        timeout_err,
    output logic                        protocol_err
);

    localparam int                BE_W       = DATA_W / 8;
    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GNT_W-1:0]   rr_ptr;
    logic [GNT_W-1:0]   rr_nxt;
    logic [GNT_W-1:0]   grant_nxt;
    logic [GNT_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [NUM_REQ-1:0] pending;
    logic               found;
    logic [GNT_W-1:0]   pick;
    logic [GNT_W:0]     cand;

    logic               g_write;
    logic               g_read;
    logic               g_cmd;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [BE_W-1:0]    be_arr    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_arr[i]  = req_address[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_writedata[i*DATA_W +: DATA_W];
        assign be_arr[i]    = req_byteenable[i*BE_W +: BE_W];
    end

    assign pending  = req_write | req_read;
    assign g_write  = req_write[grant_id];
    assign g_read   = req_read[grant_id];
    assign g_cmd    = g_write | g_read;
    assign next_ptr = (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first pending index wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (GNT_W+1)'(k);
            if (cand >= (GNT_W+1)'(NUM_REQ)) begin
                cand = cand - (GNT_W+1)'(NUM_REQ);
            end
            if (!found && pending[cand[GNT_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[GNT_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        rr_nxt              = rr_ptr;
        grant_nxt           = grant_id;
        cnt_nxt             = cnt;
        req_waitrequest     = '1;
        req_readdata        = '0;
        avmm_address_out    = '0;
        avmm_writedata_out  = '0;
        avmm_byteenable_out = '0;
        avmm_write_out      = 1'b0;
        avmm_read_out       = 1'b0;
        busy                = 1'b0;
        timeout_err         = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                    state_nxt = S_BUSY;
                end
            end

            S_BUSY: begin
                busy                      = 1'b1;
                avmm_address_out          = addr_arr[grant_id];
                avmm_writedata_out        = wdata_arr[grant_id];
                avmm_byteenable_out       = be_arr[grant_id];
                req_readdata              = avmm_readdata;
                req_waitrequest[grant_id] = avmm_waitrequest;

                if (!g_cmd) begin
                    // Requester withdrew before the slave saw anything.
                    state_nxt = S_IDLE;
                    rr_nxt    = next_ptr;
                end else if (!avmm_waitrequest) begin
                    avmm_write_out = g_write;
                    avmm_read_out  = g_read & ~g_write;
                    state_nxt      = S_IDLE;
                    rr_nxt         = next_ptr;
                end else if (cnt == CNT_LAST) begin
                    // Abort: release the requester with a poison read value.
                    req_waitrequest[grant_id] = 1'b0;
                    req_readdata              = ABORT_DATA;
                    timeout_err               = 1'b1;
                    state_nxt                 = S_IDLE;
                    rr_nxt                    = next_ptr;
                end else begin
                    avmm_write_out = g_write;
                    avmm_read_out  = g_read & ~g_write;
                    cnt_nxt        = cnt + 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            cnt          <= '0;
            protocol_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            cnt      <= cnt_nxt;
            if (state == S_BUSY && g_write && g_read) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_cfg_arbiter.sv
// Scoreboard bench for avmm_cfg_arbiter: directed transactions push expected accepts,
// a negedge monitor pops and compares whenever a requester sees waitrequest low.
module tb_avmm_cfg_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TIMEOUT = 8;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int GNT_W   = 2;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ*ADDR_W-1:0]   req_address;
    logic [NUM_REQ*DATA_W-1:0]   req_writedata;
    logic [NUM_REQ*BE_W-1:0]     req_byteenable;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ-1:0]          req_read;
    logic [NUM_REQ-1:0]          req_waitrequest;
    logic [DATA_W-1:0]           req_readdata;
    logic [ADDR_W-1:0]           avmm_address_out;
    logic [DATA_W-1:0]           avmm_writedata_out;
    logic [BE_W-1:0]             avmm_byteenable_out;
    logic                        avmm_write_out;
    logic                        avmm_read_out;
    logic [DATA_W-1:0]           avmm_readdata;
    logic                        avmm_waitrequest;
    logic                        busy;
    logic [GNT_W-1:0]            grant_id;
    logic                        timeout_err;
    logic                        protocol_err;

    logic [ADDR_W-1:0] r_addr  [NUM_REQ];
    logic [DATA_W-1:0] r_wdata [NUM_REQ];
    logic [BE_W-1:0]   r_be    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_address[i*ADDR_W +: ADDR_W]  = r_addr[i];
        assign req_writedata[i*DATA_W +: DATA_W] = r_wdata[i];
        assign req_byteenable[i*BE_W +: BE_W]    = r_be[i];
    end

    avmm_cfg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .GNT_W   (GNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_address         (req_address),
        .req_writedata       (req_writedata),
        .req_byteenable      (req_byteenable),
        .req_write           (req_write),
        .req_read            (req_read),
        .req_waitrequest     (req_waitrequest),
        .req_readdata        (req_readdata),
        .avmm_address_out    (avmm_address_out),
        .avmm_writedata_out  (avmm_writedata_out),
        .avmm_byteenable_out (avmm_byteenable_out),
        .avmm_write_out      (avmm_write_out),
        .avmm_read_out       (avmm_read_out),
        .avmm_readdata       (avmm_readdata),
        .avmm_waitrequest    (avmm_waitrequest),
        .busy                (busy),
        .grant_id            (grant_id),
        .timeout_err         (timeout_err),
        .protocol_err        (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: waitrequest stays high for wait_n cycles of each presented command.
    int wait_n;
    int stall_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 0;
        else if ((avmm_write_out || avmm_read_out) && avmm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end
    assign avmm_waitrequest = (stall_cnt < wait_n);

    int total;
    int bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                id;
        bit                wr;
        bit                to;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        int                gap;
    } exp_t;

    exp_t sb[$];

    task automatic expect_txn(input int id, input bit wr, input bit to, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be, input int gap);
        exp_t e;
        e.id = id; e.wr = wr; e.to = to; e.addr = addr; e.data = data; e.be = be; e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: every requester accept pops one expectation.
    int cyc;
    int last_cyc;
    int to_pulses;
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] exp_wait;
        cyc       = 0;
        last_cyc  = 0;
        to_pulses = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && timeout_err) to_pulses++;
            if (rst_n && req_waitrequest != '1) begin
                if (sb.size() == 0) begin
                    check("unexpected_accept", 64'(req_waitrequest), 64'(NUM_REQ'('1)));
                end else begin
                    e        = sb.pop_front();
                    exp_wait = '1;
                    exp_wait[e.id] = 1'b0;
                    check("acc_waitreq", 64'(req_waitrequest), 64'(exp_wait));
                    check("acc_grant_id", 64'(grant_id), 64'(e.id));
                    check("acc_busy", 64'(busy), 64'(1));
                    if (e.gap != 0) check("acc_gap", 64'(cyc - last_cyc), 64'(e.gap));
                    if (e.to) begin
                        check("to_write", 64'(avmm_write_out), 64'(0));
                        check("to_read", 64'(avmm_read_out), 64'(0));
                        check("to_err", 64'(timeout_err), 64'(1));
                        check("to_rdata", 64'(req_readdata), 64'(e.data));
                    end else begin
                        check("acc_timeout_err", 64'(timeout_err), 64'(0));
                        check("acc_write", 64'(avmm_write_out), 64'(e.wr));
                        check("acc_read", 64'(avmm_read_out), 64'(!e.wr));
                        check("acc_addr", 64'(avmm_address_out), 64'(e.addr));
                        if (e.wr) begin
                            check("acc_wdata", 64'(avmm_writedata_out), 64'(e.data));
                            check("acc_be", 64'(avmm_byteenable_out), 64'(e.be));
                        end else begin
                            check("acc_rdata", 64'(req_readdata), 64'(e.data));
                        end
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    // Requester driver: holds the command until accepted, then drops it after the edge.
    task automatic req_txn(input int id, input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
        int n;
        r_addr[id]    = addr;
        r_wdata[id]   = data;
        r_be[id]      = be;
        req_write[id] = wr;
        req_read[id]  = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_waitrequest[id] && n < 100);
        if (req_waitrequest[id]) check("req_accept_bound", 64'(req_waitrequest[id]), 64'(0));
        @(posedge clk);
        #1;
        req_write[id] = 1'b0;
        req_read[id]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        wait_n        = 0;
        rst_n         = 1'b0;
        req_write     = '0;
        req_read      = '0;
        avmm_readdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
            r_be[i]    = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_write", 64'(avmm_write_out), 64'(0));
        check("rst_read", 64'(avmm_read_out), 64'(0));
        check("rst_addr", 64'(avmm_address_out), 64'(0));
        check("rst_waitreq", 64'(req_waitrequest), 64'(3'b111));
        check("rst_rdata", 64'(req_readdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_errs", 64'({timeout_err, protocol_err}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two requesters writing back-to-back: grants 0,1,0,1 two cycles apart
        expect_txn(0, 1, 0, 17'h00010, 32'h0000_0A00, 4'hF, 0);
        expect_txn(1, 1, 0, 17'h00020, 32'h0000_0B10, 4'hF, 2);
        expect_txn(0, 1, 0, 17'h00011, 32'h0000_0A01, 4'hC, 2);
        expect_txn(1, 1, 0, 17'h00021, 32'h0000_0B11, 4'h3, 2);
        fork
            begin
                req_txn(0, 1, 0, 17'h00010, 32'h0000_0A00, 4'hF);
                req_txn(0, 1, 0, 17'h00011, 32'h0000_0A01, 4'hC);
            end
            begin
                req_txn(1, 1, 0, 17'h00020, 32'h0000_0B10, 4'hF);
                req_txn(1, 1, 0, 17'h00021, 32'h0000_0B11, 4'h3);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Single write from requester 0, cycle-exact
        expect_txn(0, 1, 0, 17'h00100, 32'hA5A5_0001, 4'hF, 0);
        r_addr[0] = 17'h00100; r_wdata[0] = 32'hA5A5_0001; r_be[0] = 4'hF;
        req_write[0] = 1'b1;
        @(negedge clk);
        check("w1_idle_write", 64'(avmm_write_out), 64'(0));
        check("w1_idle_waitreq", 64'(req_waitrequest), 64'(3'b111));
        @(negedge clk);
        check("w1_cmd_write", 64'(avmm_write_out), 64'(1));
        check("w1_cmd_waitreq0", 64'(req_waitrequest[0]), 64'(0));
        @(posedge clk);
        #1;
        req_write[0] = 1'b0;
        @(negedge clk);
        check("w1_after_busy", 64'(busy), 64'(0));
        check("w1_after_write", 64'(avmm_write_out), 64'(0));
        @(posedge clk);
        #1;

        // Requester 1 read with a 3-cycle slave stall
        wait_n        = 3;
        avmm_readdata = 32'h1234_5678;
        expect_txn(1, 0, 0, 17'h00204, 32'h1234_5678, 4'hF, 0);
        req_txn(1, 0, 1, 17'h00204, 32'h0, 4'hF);

        // Timeout: requester 2 read stalls forever, requester 0 is waiting behind it
        wait_n = 1000;
        expect_txn(2, 0, 1, 17'h00300, 32'hDEAD_BEEF, 4'hF, 9);
        expect_txn(0, 1, 0, 17'h003FC, 32'hCAFE_0003, 4'h3, 2);
        fork
            begin
                req_txn(2, 0, 1, 17'h00300, 32'h0, 4'hF);
                wait_n = 0;
            end
            req_txn(0, 1, 0, 17'h003FC, 32'hCAFE_0003, 4'h3);
        join
        check("timeout_pulses", 64'(to_pulses), 64'(1));

        // Read and write together: write wins, protocol_err is sticky
        @(negedge clk);
        check("perr_before", 64'(protocol_err), 64'(0));
        @(posedge clk);
        #1;
        expect_txn(1, 1, 0, 17'h00010, 32'h0000_00FF, 4'h1, 0);
        req_txn(1, 1, 1, 17'h00010, 32'h0000_00FF, 4'h1);
        @(negedge clk);
        check("perr_set", 64'(protocol_err), 64'(1));
        repeat (3) @(negedge clk);
        check("perr_sticky", 64'(protocol_err), 64'(1));

        // Reset in the middle of a stalled write
        @(posedge clk);
        #1;
        wait_n = 1000;
        r_addr[0] = 17'h00050; r_wdata[0] = 32'h5555_0050; r_be[0] = 4'hF;
        req_write[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_write_active", 64'(avmm_write_out), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", 64'(avmm_write_out), 64'(0));
        check("mid_rst_read", 64'(avmm_read_out), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_waitreq", 64'(req_waitrequest), 64'(3'b111));
        check("mid_rst_perr", 64'(protocol_err), 64'(0));
        req_write[0] = 1'b0;
        wait_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset rr_ptr is 0, so requester 1 beats requester 2
        expect_txn(1, 1, 0, 17'h00061, 32'h1111_0061, 4'hF, 0);
        expect_txn(2, 1, 0, 17'h00062, 32'h2222_0062, 4'hF, 2);
        fork
            req_txn(1, 1, 0, 17'h00061, 32'h1111_0061, 4'hF);
            req_txn(2, 1, 0, 17'h00062, 32'h2222_0062, 4'hF);
        join
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
